// File: rtl/isp_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : isp_frame_loader
// Description : In-system programming loader. Parses one load frame from a
//               byte stream and writes little-endian 32-bit words into core
//               program memory, then launches the core on a good checksum.
//               Frame: 0xA5 | LEN_LO | LEN_HI | 4*LEN payload bytes | CHK
//               LEN is a word count, CHK is the XOR of all payload bytes.
// Ports       : clock, reset          - rising-edge clock, sync active-high reset
//               rx_data/rx_valid      - byte stream in
//               rx_ready              - byte accepted when rx_valid && rx_ready
//               isp_write/address/data- one-cycle word write to program memory
//               start/prog_address    - one-cycle launch pulse with entry point
//               busy                  - parsing a frame (not IDLE, not ERROR)
//               error                 - sticky checksum / length failure
// Revision    : 1.0 - initial release
// ============================================================================
module isp_frame_loader #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDRESS_BITS = 12,
    parameter logic [19:0] PROG_ENTRY   = 20'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    isp_write,
    output logic [ADDRESS_BITS-1:0] isp_address,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic                    start,
    output logic [19:0]             prog_address,
    output logic                    busy,
    output logic                    error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_LEN_HI  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_LAUNCH  = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [7:0]  c_SYNC    = 8'hA5;
    // Largest legal word count: exactly fills the ISP address space.
    localparam logic [16:0] c_MAX_LEN = 17'd1 << ADDRESS_BITS;

    logic [2:0]              state_q,   state_d;
    logic [7:0]              len_lo_q,  len_lo_d;
    logic [15:0]             len_q,     len_d;
    logic [ADDRESS_BITS-1:0] addr_q,    addr_d;
    logic [1:0]              lane_q,    lane_d;
    logic [23:0]             word_q,    word_d;     // lanes 0..2 of the current word
    logic [7:0]              chk_q,     chk_d;
    logic                    wr_q,      wr_d;
    logic [ADDRESS_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_last_word;

    assign w_accept    = rx_valid && rx_ready;
    assign w_len       = {rx_data, len_lo_q};
    assign w_last_word = (16'(addr_q) == (len_q - 16'd1));

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        word_d    = word_q;
        chk_d     = chk_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                // Non-sync bytes are consumed and dropped; sync also clears error.
                if (w_accept && rx_data == c_SYNC) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    len_d  = w_len;
                    addr_d = '0;
                    lane_d = 2'd0;
                    chk_d  = 8'd0;
                    if ({1'b0, w_len} > c_MAX_LEN) begin
                        state_d = S_ERROR;
                    end else if (w_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    chk_d  = chk_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            wr_d      = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {rx_data, word_q};
                            // Hold the address on the last word so it never wraps.
                            if (w_last_word) begin
                                state_d = S_CHECK;
                            end else begin
                                addr_d = addr_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    state_d = (rx_data == chk_q) ? S_LAUNCH : S_ERROR;
                end
            end
            S_LAUNCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_lo_q  <= 8'd0;
            len_q     <= 16'd0;
            addr_q    <= '0;
            lane_q    <= 2'd0;
            word_q    <= 24'd0;
            chk_q     <= 8'd0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            chk_q     <= chk_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rx_ready     = (state_q != S_LAUNCH);
    assign isp_write    = wr_q;
    assign isp_address  = wr_addr_q;
    assign isp_data     = wr_data_q;
    assign start        = (state_q == S_LAUNCH);
    assign prog_address = start ? PROG_ENTRY : 20'd0;
    assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign error        = (state_q == S_ERROR);

endmodule
`default_nettype wire
